// File: rtl/poly_lift_stream.sv
// Streaming NTRU lift: m1 = S3(m/Phi1) with m1[N-1]=0, m0 = (x-1)*m1 in Rq, LANES coeffs per beat.
// One frame at a time: LOAD the whole of m, one PREP cycle, then EMIT under valid/ready.
module poly_lift_stream #(
   parameter int NTRU_N = 701,
   parameter int Q_BITS = 13,
   parameter int LANES  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*LANES-1:0]      in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [Q_BITS*LANES-1:0] out_m0,
   output logic [2*LANES-1:0]      out_m1,
   output logic                    out_last,
   output logic                    busy
);
   localparam int BEATS = (NTRU_N + LANES - 1) / LANES;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam bit K_IS_SUM = (NTRU_N % 3) == 2;

   if (NTRU_N % 3 == 0) begin : g_bad_n
      $error("poly_lift_stream: NTRU_N must not be a multiple of 3");
   end

   typedef enum logic [1:0] {S_LOAD, S_PREP, S_EMIT} state_t;

   // Coefficients are kept as residues 0,1,2 where 2 doubles as the -1 wire code.
   function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   function automatic logic [1:0] neg3(input logic [1:0] a);
      return (a == 2'd0) ? 2'd0 : 2'd3 - a;
   endfunction

   function automatic logic [1:0] norm3(input logic [1:0] a);
      return (a == 2'b11) ? 2'b00 : a;
   endfunction

   function automatic logic signed [2:0] sval(input logic [1:0] a);
      return (a == 2'd2) ? -3'sd1 : $signed({1'b0, a});
   endfunction

   state_t                   state_q, state_d;
   logic [CW-1:0]            in_cnt_q, in_cnt_d;
   logic [CW-1:0]            out_cnt_q, out_cnt_d;
   logic [1:0]               sum_q, sum_d;
   logic [1:0]               k_q, k_d;
   logic [1:0]               c_q, c_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic                     busy_q, busy_d;
   logic [Q_BITS*LANES-1:0]  out_m0_q, out_m0_d;
   logic [2*LANES-1:0]       out_m1_q, out_m1_d;
   logic [2*LANES-1:0]       buf_q [BEATS];

   logic                     in_fire, out_fire, wr_en;
   logic [2*LANES-1:0]       wr_dat;
   logic [1:0]               beat_sum, k_new, k_use, prev, m1v, calc_c;
   logic signed [2:0]        d;
   logic [CW-1:0]            rd_beat;
   logic [Q_BITS*LANES-1:0]  calc_m0;
   logic [2*LANES-1:0]       calc_m1;

   assign in_fire  = (state_q == S_LOAD) && in_ready_q && in_valid;
   assign out_fire = (state_q == S_EMIT) && out_valid_q && out_ready;
   assign k_new    = K_IS_SUM ? sum_q : neg3(sum_q);

   // Lanes past the end of the polynomial are dropped before they reach the buffer or the sum.
   always_comb begin
      wr_dat   = '0;
      beat_sum = sum_q;
      for (int j = 0; j < LANES; j++) begin
         if (int'(in_cnt_q) * LANES + j < NTRU_N) begin
            wr_dat[2*j +: 2] = norm3(in_data[2*j +: 2]);
            beat_sum = add3(beat_sum, norm3(in_data[2*j +: 2]));
         end
      end
   end

   // Lane chain: m1[i] = m1[i-1] - m[i] - k, m0[i] = m1[i-1] - m1[i] as a small signed integer.
   always_comb begin
      rd_beat = '0;
      if (state_q == S_EMIT && !out_last_q) rd_beat = out_cnt_q + CW'(1);
      k_use   = (state_q == S_PREP) ? k_new : k_q;
      prev    = (state_q == S_PREP) ? 2'd0 : c_q;
      calc_m0 = '0;
      calc_m1 = '0;
      m1v     = '0;
      d       = '0;
      for (int j = 0; j < LANES; j++) begin
         if (int'(rd_beat) * LANES + j < NTRU_N) begin
            m1v = add3(prev, neg3(add3(buf_q[rd_beat][2*j +: 2], k_use)));
            d   = sval(prev) - sval(m1v);
            calc_m1[2*j +: 2]           = m1v;
            calc_m0[Q_BITS*j +: Q_BITS] = {{(Q_BITS-3){d[2]}}, d};
            prev = m1v;
         end
      end
      calc_c = prev;
   end

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      sum_d       = sum_q;
      k_d         = k_q;
      c_d         = c_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_m0_d    = out_m0_q;
      out_m1_d    = out_m1_q;
      wr_en       = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready_d = 1'b1;
            if (in_fire) begin
               wr_en = 1'b1;
               sum_d = beat_sum;
               if (in_cnt_q == LAST_BEAT) begin
                  in_cnt_d   = '0;
                  in_ready_d = 1'b0;
                  state_d    = S_PREP;
               end else begin
                  in_cnt_d = in_cnt_q + CW'(1);
               end
            end
         end
         S_PREP: begin
            k_d         = k_new;
            sum_d       = '0;
            c_d         = calc_c;
            out_m0_d    = calc_m0;
            out_m1_d    = calc_m1;
            out_cnt_d   = '0;
            out_last_d  = (BEATS == 1);
            out_valid_d = 1'b1;
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            if (out_fire) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = S_LOAD;
               end else begin
                  out_cnt_d  = rd_beat;
                  c_d        = calc_c;
                  out_m0_d   = calc_m0;
                  out_m1_d   = calc_m1;
                  out_last_d = (rd_beat == LAST_BEAT);
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
      busy_d = (state_d != S_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         sum_q       <= '0;
         k_q         <= '0;
         c_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_m0_q    <= '0;
         out_m1_q    <= '0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         sum_q       <= sum_d;
         k_q         <= k_d;
         c_q         <= c_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         out_m0_q    <= out_m0_d;
         out_m1_q    <= out_m1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buf_q[in_cnt_q] <= wr_dat;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_m0    = out_m0_q;
   assign out_m1    = out_m1_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_poly_lift_stream.sv
// Directed bench for poly_lift_stream across four configurations (N=5 x1/x2 lanes, N=7, N=701 x2).
// Outputs are collected per frame, then checked against hand tables and the algebraic lift identity.
module tb_poly_lift_stream;
   localparam int Q = 13;

   logic        clk;
   logic        rst_n   [4];
   logic        in_vld  [4];
   logic        in_rdy  [4];
   logic [3:0]  in_dat  [4];
   logic        out_vld [4];
   logic        out_rdy [4];
   logic [25:0] m0_w    [4];
   logic [3:0]  m1_w    [4];
   logic        last_w  [4];
   logic        busy_w  [4];

   logic [1:0]  raw  [701];
   logic [1:0]  g_m1 [701];
   logic [12:0] g_m0 [701];
   logic [1:0]  e_m1 [8];
   logic [12:0] e_m0 [8];
   int          n_cmp, n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign m0_w[0][25:13] = '0;
   assign m1_w[0][3:2]   = '0;
   assign m0_w[2][25:13] = '0;
   assign m1_w[2][3:2]   = '0;

   poly_lift_stream #(.NTRU_N(5), .Q_BITS(Q), .LANES(1)) u_n5l1 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_vld[0]), .in_ready(in_rdy[0]),
      .in_data(in_dat[0][1:0]), .out_valid(out_vld[0]), .out_ready(out_rdy[0]),
      .out_m0(m0_w[0][12:0]), .out_m1(m1_w[0][1:0]), .out_last(last_w[0]), .busy(busy_w[0]));
   poly_lift_stream #(.NTRU_N(5), .Q_BITS(Q), .LANES(2)) u_n5l2 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_vld[1]), .in_ready(in_rdy[1]),
      .in_data(in_dat[1]), .out_valid(out_vld[1]), .out_ready(out_rdy[1]),
      .out_m0(m0_w[1]), .out_m1(m1_w[1]), .out_last(last_w[1]), .busy(busy_w[1]));
   poly_lift_stream #(.NTRU_N(7), .Q_BITS(Q), .LANES(1)) u_n7l1 (
      .clk(clk), .rst_n(rst_n[2]), .in_valid(in_vld[2]), .in_ready(in_rdy[2]),
      .in_data(in_dat[2][1:0]), .out_valid(out_vld[2]), .out_ready(out_rdy[2]),
      .out_m0(m0_w[2][12:0]), .out_m1(m1_w[2][1:0]), .out_last(last_w[2]), .busy(busy_w[2]));
   poly_lift_stream #(.NTRU_N(701), .Q_BITS(Q), .LANES(2)) u_n701l2 (
      .clk(clk), .rst_n(rst_n[3]), .in_valid(in_vld[3]), .in_ready(in_rdy[3]),
      .in_data(in_dat[3]), .out_valid(out_vld[3]), .out_ready(out_rdy[3]),
      .out_m0(m0_w[3]), .out_m1(m1_w[3]), .out_last(last_w[3]), .busy(busy_w[3]));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int dec(input logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b10) return -1;
      return 0;
   endfunction

   task automatic send_frame(input int u, input int n, input int lanes);
      int beats, t, idx;
      beats = (n + lanes - 1) / lanes;
      for (int b = 0; b < beats; b++) begin
         in_dat[u] = '0;
         for (int j = 0; j < lanes; j++) begin
            idx = b * lanes + j;
            if (idx < n) in_dat[u][2*j +: 2] = raw[idx];
            else         in_dat[u][2*j +: 2] = 2'b01;
         end
         in_vld[u] = 1'b1;
         t = 0;
         while (in_rdy[u] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 50) check("in_ready_wait", 32'(in_rdy[u]), 32'd1);
         @(posedge clk); #1;
      end
      in_vld[u] = 1'b0;
   endtask

   // mode 0: always ready, 1: ready toggles 1010.., 2: three-cycle stall while beat 1 is offered
   task automatic recv_frame(input int u, input int n, input int lanes, input int mode);
      int beats, b, cyc, stall, unstable, rdy_viol, pad_bad, last_bad, idx;
      logic [25:0] h_m0;
      logic [3:0]  h_m1;
      logic        h_last, rdy;
      bit          held;
      beats = (n + lanes - 1) / lanes;
      b = 0; cyc = 0; stall = 0; unstable = 0; rdy_viol = 0; pad_bad = 0; last_bad = 0;
      held = 1'b0; h_m0 = '0; h_m1 = '0; h_last = 1'b0;
      while (b < beats && cyc < 4000) begin
         rdy = 1'b1;
         if (mode == 1) rdy = (cyc % 2 == 0);
         if (mode == 2 && b == 1 && stall < 3) begin
            rdy = 1'b0;
            stall++;
         end
         out_rdy[u] = rdy;
         if (in_rdy[u] !== 1'b0) rdy_viol++;
         if (out_vld[u] === 1'b1) begin
            if (held && (m0_w[u] !== h_m0 || m1_w[u] !== h_m1 || last_w[u] !== h_last)) unstable++;
            if (rdy) begin
               for (int j = 0; j < lanes; j++) begin
                  idx = b * lanes + j;
                  if (idx < n) begin
                     g_m1[idx] = m1_w[u][2*j +: 2];
                     g_m0[idx] = m0_w[u][Q*j +: Q];
                  end else if (m1_w[u][2*j +: 2] !== 2'b00 || m0_w[u][Q*j +: Q] !== '0) begin
                     pad_bad++;
                  end
               end
               if (last_w[u] !== (b == beats - 1)) last_bad++;
               b++;
               held = 1'b0;
            end else begin
               h_m0 = m0_w[u]; h_m1 = m1_w[u]; h_last = last_w[u];
               held = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_rdy[u] = 1'b0;
      check($sformatf("u%0d_beats_received", u), b, beats);
      check($sformatf("u%0d_stable_while_stalled", u), unstable, 0);
      check($sformatf("u%0d_in_ready_low_during_emit", u), rdy_viol, 0);
      check($sformatf("u%0d_padding_lanes_zero", u), pad_bad, 0);
      check($sformatf("u%0d_out_last_position", u), last_bad, 0);
   endtask

   task automatic run_frame(input int u, input int n, input int lanes, input int mode);
      send_frame(u, n, lanes);
      check($sformatf("u%0d_prep_out_valid", u), 32'(out_vld[u]), 32'd0);
      check($sformatf("u%0d_prep_busy", u), 32'(busy_w[u]), 32'd1);
      check($sformatf("u%0d_prep_in_ready", u), 32'(in_rdy[u]), 32'd0);
      @(posedge clk); #1;
      check($sformatf("u%0d_first_out_valid", u), 32'(out_vld[u]), 32'd1);
      recv_frame(u, n, lanes, mode);
      check($sformatf("u%0d_end_out_valid", u), 32'(out_vld[u]), 32'd0);
      check($sformatf("u%0d_end_in_ready", u), 32'(in_rdy[u]), 32'd1);
      check($sformatf("u%0d_end_busy", u), 32'(busy_w[u]), 32'd0);
   endtask

   task automatic check_hand(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_m1[%0d]", tag, i), 32'(g_m1[i]), 32'(e_m1[i]));
         check($sformatf("%s_m0[%0d]", tag, i), 32'(g_m0[i]), 32'(e_m0[i]));
      end
   endtask

   // Every m0[i] must equal m1[i-1]-m1[i] exactly and be congruent to m[i]+k mod 3.
   task automatic check_model(input string tag, input int n);
      int sum, k, bad, pv, cv, dv, r;
      sum = 0; bad = 0;
      for (int i = 0; i < n; i++) sum += dec(raw[i]);
      sum = ((sum % 3) + 3) % 3;
      k = (n % 3 == 2) ? sum : (3 - sum) % 3;
      for (int i = 0; i < n; i++) begin
         pv = (i == 0) ? 0 : dec(g_m1[i-1]);
         cv = dec(g_m1[i]);
         dv = pv - cv;
         r  = (((dv - dec(raw[i]) - k) % 3) + 3) % 3;
         if (g_m1[i] === 2'b11 || g_m0[i] !== 13'(dv) || r != 0) bad++;
      end
      check($sformatf("%s_lift_identity_bad", tag), bad, 0);
      check($sformatf("%s_m1_top", tag), 32'(g_m1[n-1]), 32'd0);
   endtask

   initial begin
      int nz;
      n_cmp = 0; n_bad = 0;
      for (int u = 0; u < 4; u++) begin
         rst_n[u] = 1'b0; in_vld[u] = 1'b0; out_rdy[u] = 1'b0; in_dat[u] = '0;
      end
      #2;
      check("rst_out_valid", 32'(out_vld[0]), 32'd0);
      check("rst_in_ready", 32'(in_rdy[0]), 32'd0);
      check("rst_busy", 32'(busy_w[0]), 32'd0);
      check("rst_out_last", 32'(last_w[0]), 32'd0);
      check("rst_out_m0", 32'(m0_w[1]), 32'd0);
      check("rst_out_m1", 32'(m1_w[1]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) rst_n[u] = 1'b1;
      check("in_ready_before_first_edge", 32'(in_rdy[0]), 32'd0);
      @(posedge clk); #1;
      for (int u = 0; u < 4; u++) check($sformatf("u%0d_in_ready_after_release", u), 32'(in_rdy[u]), 32'd1);

      // N=5, single impulse: k=+1
      for (int i = 0; i < 701; i++) raw[i] = 2'b00;
      raw[0] = 2'b01;
      e_m1 = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      e_m0 = '{13'h1FFF, 13'h0001, 13'h0001, 13'h1FFE, 13'h0001, 13'h0, 13'h0, 13'h0};
      run_frame(0, 5, 1, 0);
      check_hand("n5l1_impulse", 5);
      check_model("n5l1_impulse", 5);

      // N=5 zero polynomial, with the unused 2'b11 code standing in for a zero
      raw[0] = 2'b00; raw[1] = 2'b11;
      e_m1 = '{default: 2'b00};
      e_m0 = '{default: 13'h0};
      run_frame(0, 5, 1, 1);
      check_hand("n5l1_zero", 5);

      // N=5 two lanes: last beat carries one real lane and one pad lane
      raw[0] = 2'b01; raw[1] = 2'b00;
      e_m1 = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      e_m0 = '{13'h1FFF, 13'h0001, 13'h0001, 13'h1FFE, 13'h0001, 13'h0, 13'h0, 13'h0};
      run_frame(1, 5, 2, 0);
      check_hand("n5l2_impulse", 5);

      // N=7 (k = -sum): m=[+1,+1,0,...] gives k=+1
      raw[0] = 2'b01; raw[1] = 2'b01;
      e_m1 = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
      e_m0 = '{13'h1FFF, 13'h0002, 13'h1FFE, 13'h0001, 13'h0001, 13'h1FFE, 13'h0001, 13'h0};
      run_frame(2, 7, 1, 2);
      check_hand("n7l1", 7);
      check_model("n7l1", 7);

      // N=701: abort a random frame at output beat 2 with reset
      for (int i = 0; i < 701; i++) raw[i] = 2'($urandom_range(0, 3));
      send_frame(3, 701, 2);
      @(posedge clk); #1;
      out_rdy[3] = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("abort_pre_out_valid", 32'(out_vld[3]), 32'd1);
      rst_n[3] = 1'b0;
      out_rdy[3] = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_vld[3]), 32'd0);
      check("abort_out_last", 32'(last_w[3]), 32'd0);
      check("abort_busy", 32'(busy_w[3]), 32'd0);
      check("abort_in_ready", 32'(in_rdy[3]), 32'd0);
      @(posedge clk); #1;
      rst_n[3] = 1'b1;
      @(posedge clk); #1;
      check("abort_in_ready_after_release", 32'(in_rdy[3]), 32'd1);

      // all +1: sum=2, k=-1, so every m1 and m0 is zero
      for (int i = 0; i < 701; i++) raw[i] = 2'b01;
      run_frame(3, 701, 2, 1);
      check_model("n701_ones", 701);
      nz = 0;
      for (int i = 0; i < 701; i++) if (g_m1[i] !== 2'b00 || g_m0[i] !== 13'h0) nz++;
      check("n701_ones_nonzero_coeffs", nz, 0);

      // random full frame after the abort, with stalls
      for (int i = 0; i < 701; i++) raw[i] = 2'($urandom_range(0, 3));
      run_frame(3, 701, 2, 2);
      check_model("n701_random", 701);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
